// File: rtl/onchip_priority_heap.sv
// Binary-heap priority queue (key+payload) held in on-chip RAM, root cached in a register.
// Push sifts up from the new leaf; pop/replace sifts the displaced entry down from the root.
module onchip_priority_heap #(
  parameter int W_KEY    = 32,
  parameter int W_VAL    = 16,
  parameter int W_A      = 8,
  parameter int MODE_MIN = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [W_KEY-1:0] push_key,
  input  logic [W_VAL-1:0] push_val,
  input  logic             pop_valid,
  output logic             pop_ready,
  output logic             pop_out_valid,
  output logic [W_KEY-1:0] pop_key,
  output logic [W_VAL-1:0] pop_val,
  input  logic             flush,
  output logic [W_A-1:0]   count,
  output logic             empty,
  output logic             full
);
  localparam int W_I = W_A + 1;
  localparam int W_E = W_KEY + W_VAL;
  localparam logic [W_A-1:0] CAP_C = '1;

  typedef enum logic [3:0] {
    IDLE, DN_LOAD, DN_L, DN_R, DN_CMP, DN_FIN, UP_RD, UP_CMP, UP_FIN
  } state_t;

  function automatic logic better(input logic [W_KEY-1:0] a, input logic [W_KEY-1:0] b);
    if (MODE_MIN != 0) return a < b;
    else return a > b;
  endfunction

  state_t           state_q, state_d;
  logic [W_A-1:0]   count_q, count_d;
  logic [W_I-1:0]   idx_q, idx_d;
  logic [W_KEY-1:0] new_key_q, new_key_d, root_key_q, root_key_d, left_key_q, left_key_d;
  logic [W_VAL-1:0] new_val_q, new_val_d, root_val_q, root_val_d, left_val_q, left_val_d;
  logic             pop_out_valid_q, pop_out_valid_d;
  logic [W_KEY-1:0] pop_key_q, pop_key_d;
  logic [W_VAL-1:0] pop_val_q, pop_val_d;

  logic [W_E-1:0]   mem [0:(2**W_A)-1];
  logic [W_E-1:0]   rd_q;
  logic             mem_we, mem_re;
  logic [W_A-1:0]   mem_wa, mem_ra;
  logic [W_E-1:0]   mem_wd;

  logic [W_KEY-1:0] rd_key, c_key;
  logic [W_VAL-1:0] rd_val, c_val;
  logic [W_I-1:0]   count_ext, idx2, idx2p1, c_idx;
  logic             take_right;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CAP_C);
  assign count      = count_q;
  assign pop_ready  = (state_q == IDLE) && !empty && !flush;
  assign push_ready = (state_q == IDLE) && !flush && (!full || (pop_valid && !empty));
  assign pop_out_valid = pop_out_valid_q;
  assign pop_key    = pop_key_q;
  assign pop_val    = pop_val_q;

  assign rd_key     = rd_q[W_E-1:W_VAL];
  assign rd_val     = rd_q[W_VAL-1:0];
  assign count_ext  = {1'b0, count_q};
  assign idx2       = {idx_q[W_A-1:0], 1'b0};
  assign idx2p1     = {idx_q[W_A-1:0], 1'b1};
  // In DN_CMP the read data is the right child; it only competes if it exists.
  assign take_right = (idx2p1 <= count_ext) && better(rd_key, left_key_q);
  assign c_key      = take_right ? rd_key : left_key_q;
  assign c_val      = take_right ? rd_val : left_val_q;
  assign c_idx      = take_right ? idx2p1 : idx2;

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    idx_d           = idx_q;
    new_key_d       = new_key_q;
    new_val_d       = new_val_q;
    root_key_d      = root_key_q;
    root_val_d      = root_val_q;
    left_key_d      = left_key_q;
    left_val_d      = left_val_q;
    pop_out_valid_d = 1'b0;
    pop_key_d       = pop_key_q;
    pop_val_d       = pop_val_q;
    mem_we          = 1'b0;
    mem_wa          = '0;
    mem_wd          = '0;
    mem_re          = 1'b0;
    mem_ra          = '0;
    if (flush) begin
      count_d = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop_valid && push_valid && !empty) begin
            pop_out_valid_d = 1'b1;
            pop_key_d       = root_key_q;
            pop_val_d       = root_val_q;
            new_key_d       = push_key;
            new_val_d       = push_val;
            idx_d           = W_I'(1);
            state_d         = DN_L;
          end else if (pop_valid && !empty) begin
            pop_out_valid_d = 1'b1;
            pop_key_d       = root_key_q;
            pop_val_d       = root_val_q;
            count_d         = count_q - 1'b1;
            if (count_q != W_A'(1)) begin
              mem_re  = 1'b1;
              mem_ra  = count_q;
              state_d = DN_LOAD;
            end
          end else if (push_valid && empty) begin
            root_key_d = push_key;
            root_val_d = push_val;
            mem_we     = 1'b1;
            mem_wa     = W_A'(1);
            mem_wd     = {push_key, push_val};
            count_d    = W_A'(1);
          end else if (push_valid && !full) begin
            count_d   = count_q + 1'b1;
            new_key_d = push_key;
            new_val_d = push_val;
            idx_d     = count_ext + 1'b1;
            state_d   = UP_RD;
          end
        end
        DN_LOAD: begin
          new_key_d = rd_key;
          new_val_d = rd_val;
          idx_d     = W_I'(1);
          state_d   = DN_L;
        end
        DN_L: begin
          if (idx2 > count_ext) begin
            state_d = DN_FIN;
          end else begin
            mem_re  = 1'b1;
            mem_ra  = idx2[W_A-1:0];
            state_d = DN_R;
          end
        end
        DN_R: begin
          left_key_d = rd_key;
          left_val_d = rd_val;
          mem_re     = 1'b1;
          mem_ra     = idx2p1[W_A-1:0];
          state_d    = DN_CMP;
        end
        DN_CMP: begin
          if (better(c_key, new_key_q)) begin
            mem_we = 1'b1;
            mem_wa = idx_q[W_A-1:0];
            mem_wd = {c_key, c_val};
            if (idx_q == W_I'(1)) begin
              root_key_d = c_key;
              root_val_d = c_val;
            end
            idx_d   = c_idx;
            state_d = DN_L;
          end else begin
            state_d = DN_FIN;
          end
        end
        DN_FIN: begin
          mem_we = 1'b1;
          mem_wa = idx_q[W_A-1:0];
          mem_wd = {new_key_q, new_val_q};
          if (idx_q == W_I'(1)) begin
            root_key_d = new_key_q;
            root_val_d = new_val_q;
          end
          state_d = IDLE;
        end
        UP_RD: begin
          mem_re  = 1'b1;
          mem_ra  = idx_q[W_A:1];
          state_d = UP_CMP;
        end
        UP_CMP: begin
          mem_we = 1'b1;
          mem_wa = idx_q[W_A-1:0];
          if (better(new_key_q, rd_key)) begin
            mem_wd  = rd_q;
            idx_d   = idx_q >> 1;
            // The root lives in a register, so the last step is resolved against it.
            state_d = ((idx_q >> 1) == W_I'(1)) ? UP_FIN : UP_RD;
          end else begin
            mem_wd  = {new_key_q, new_val_q};
            state_d = IDLE;
          end
        end
        UP_FIN: begin
          mem_we = 1'b1;
          mem_wa = W_A'(1);
          if (better(new_key_q, root_key_q)) begin
            root_key_d = new_key_q;
            root_val_d = new_val_q;
            mem_wd     = {new_key_q, new_val_q};
          end else begin
            mem_wd     = {root_key_q, root_val_q};
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= IDLE;
      count_q         <= '0;
      idx_q           <= '0;
      new_key_q       <= '0;
      new_val_q       <= '0;
      root_key_q      <= '0;
      root_val_q      <= '0;
      left_key_q      <= '0;
      left_val_q      <= '0;
      pop_out_valid_q <= 1'b0;
      pop_key_q       <= '0;
      pop_val_q       <= '0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      idx_q           <= idx_d;
      new_key_q       <= new_key_d;
      new_val_q       <= new_val_d;
      root_key_q      <= root_key_d;
      root_val_q      <= root_val_d;
      left_key_q      <= left_key_d;
      left_val_q      <= left_val_d;
      pop_out_valid_q <= pop_out_valid_d;
      pop_key_q       <= pop_key_d;
      pop_val_q       <= pop_val_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
    if (mem_re) rd_q <= mem[mem_ra];
  end
endmodule

// File: tb/tb_onchip_priority_heap.sv
// Bench for onchip_priority_heap: a min-heap and a max-heap instance (capacity 7 each),
// directed vector tables, hand-written corner sequences and a random run against a list model.
module tb_onchip_priority_heap;
  localparam int WK  = 32;
  localparam int WV  = 16;
  localparam int WA  = 3;
  localparam int CAP = 7;

  typedef struct {
    logic [WK-1:0] key;
    logic [WV-1:0] val;
  } exp_t;

  typedef struct {
    int            s;
    bit            pu;
    bit            po;
    logic [WK-1:0] key;
    logic [WV-1:0] val;
    logic [WK-1:0] ek;
    logic [WV-1:0] ev;
    int            ecnt;
  } vec_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic          push_valid [2];
  logic          pop_valid  [2];
  logic          flush      [2];
  logic          push_ready [2];
  logic          pop_ready  [2];
  logic          pop_out_valid [2];
  logic          empty      [2];
  logic          full       [2];
  logic [WK-1:0] push_key   [2];
  logic [WK-1:0] pop_key    [2];
  logic [WV-1:0] push_val   [2];
  logic [WV-1:0] pop_val    [2];
  logic [WA-1:0] count      [2];

  int total = 0;
  int bad   = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  logic [WK-1:0] mdl[$];
  int   mdl_s   = 0;
  bit   chk_cnt = 1'b0;
  vec_t vt[$];

  always #5 CLK = ~CLK;

  // Instance 0 keeps the smallest key at the root, instance 1 the largest.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    onchip_priority_heap #(
      .W_KEY(WK), .W_VAL(WV), .W_A(WA), .MODE_MIN((gi == 0) ? 1 : 0)
    ) u_dut (
      .CLK(CLK), .RST(RST),
      .push_valid(push_valid[gi]), .push_ready(push_ready[gi]),
      .push_key(push_key[gi]), .push_val(push_val[gi]),
      .pop_valid(pop_valid[gi]), .pop_ready(pop_ready[gi]),
      .pop_out_valid(pop_out_valid[gi]), .pop_key(pop_key[gi]), .pop_val(pop_val[gi]),
      .flush(flush[gi]), .count(count[gi]), .empty(empty[gi]), .full(full[gi])
    );
  end

  function automatic logic [WV-1:0] vof(input logic [WK-1:0] k);
    return k[WV-1:0] ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic sb_push(input int s, input logic [WK-1:0] k, input logic [WV-1:0] v);
    exp_t e;
    e.key = k;
    e.val = v;
    if (s == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask

  function automatic int sb_size(input int s);
    return (s == 0) ? sb0.size() : sb1.size();
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge CLK);
    #1;
    for (int s = 0; s < 2; s++) begin
      if (pop_out_valid[s]) begin
        if (sb_size(s) == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop dut%0d: got key %0d want no output", s, pop_key[s]);
        end else begin
          e = (s == 0) ? sb0.pop_front() : sb1.pop_front();
          $display("pop dut%0d key=%0d val=%0h (want %0d/%0h)", s, pop_key[s], pop_val[s], e.key, e.val);
          check("pop_key", 64'(pop_key[s]), 64'(e.key));
          check("pop_val", 64'(pop_val[s]), 64'(e.val));
        end
      end
    end
    if (chk_cnt) begin
      check("count", 64'(count[mdl_s]), 64'(mdl.size()));
      check("empty", 64'(empty[mdl_s]), 64'(mdl.size() == 0));
      check("full",  64'(full[mdl_s]),  64'(mdl.size() == CAP));
    end
  endtask

  task automatic wait_idle(input int s);
    int n = 0;
    while (!(push_ready[s] || pop_ready[s]) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL idle_timeout dut%0d: got busy after %0d cycles want idle", s, n);
    end
  endtask

  task automatic drain_check(input int s);
    if (sb_size(s) != 0) begin
      total++;
      bad++;
      $display("FAIL missing_pop dut%0d: got %0d pending want 0", s, sb_size(s));
      if (s == 0) sb0.delete();
      else sb1.delete();
    end
  endtask

  // One accepted request; the pop expectation is queued when the bench drives it.
  task automatic op(input int s, input bit pu, input bit po, input logic [WK-1:0] k,
                    input logic [WV-1:0] v, input bit do_exp,
                    input logic [WK-1:0] ek, input logic [WV-1:0] ev);
    wait_idle(s);
    push_valid[s] = pu;
    pop_valid[s]  = po;
    push_key[s]   = k;
    push_val[s]   = v;
    #1;
    if (po && do_exp) sb_push(s, ek, ev);
    tick();
    push_valid[s] = 1'b0;
    pop_valid[s]  = 1'b0;
    drain_check(s);
  endtask

  task automatic add(input int s, input bit pu, input bit po, input logic [WK-1:0] k,
                     input logic [WV-1:0] v, input logic [WK-1:0] ek,
                     input logic [WV-1:0] ev, input int ecnt);
    vec_t r;
    r.s = s; r.pu = pu; r.po = po; r.key = k; r.val = v;
    r.ek = ek; r.ev = ev; r.ecnt = ecnt;
    vt.push_back(r);
  endtask

  task automatic mdl_take(input int s, output logic [WK-1:0] k);
    int bi = 0;
    for (int i = 1; i < mdl.size(); i++) begin
      if ((s == 0) ? (mdl[i] < mdl[bi]) : (mdl[i] > mdl[bi])) bi = i;
    end
    k = mdl[bi];
    mdl.delete(bi);
  endtask

  task automatic rand_op(input int s);
    int r;
    bit pu, po;
    int n;
    logic [WK-1:0] k, ek;
    r = $urandom_range(0, 99);
    if (r < 5) begin
      flush[s] = 1'b1;
      #1;
      check("flush_pop_ready",  64'(pop_ready[s]),  64'(0));
      check("flush_push_ready", 64'(push_ready[s]), 64'(0));
      mdl.delete();
      tick();
      flush[s] = 1'b0;
    end else begin
      wait_idle(s);
      pu = (r < 50) || (r >= 85);
      po = (r >= 50);
      k  = 32'($urandom_range(0, 40));
      n  = mdl.size();
      push_valid[s] = pu;
      pop_valid[s]  = po;
      push_key[s]   = k;
      push_val[s]   = vof(k);
      #1;
      check("rnd_pop_ready",  64'(pop_ready[s]),  64'(n > 0));
      check("rnd_push_ready", 64'(push_ready[s]), 64'((n < CAP) || (po && n > 0)));
      if (po && n > 0) begin
        mdl_take(s, ek);
        sb_push(s, ek, vof(ek));
        if (pu) mdl.push_back(k);
      end else if (pu && n < CAP) begin
        mdl.push_back(k);
      end
      tick();
      push_valid[s] = 1'b0;
      pop_valid[s]  = 1'b0;
      drain_check(s);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WK-1:0] keys3 [7];
    for (int s = 0; s < 2; s++) begin
      push_valid[s] = 1'b0; pop_valid[s] = 1'b0; flush[s] = 1'b0;
      push_key[s] = '0; push_val[s] = '0;
    end
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      check("rst_count", 64'(count[s]), 64'(0));
      check("rst_empty", 64'(empty[s]), 64'(1));
      check("rst_full",  64'(full[s]),  64'(0));
      check("rst_push_ready", 64'(push_ready[s]), 64'(1));
      check("rst_pop_ready",  64'(pop_ready[s]),  64'(0));
      check("rst_pop_out_valid", 64'(pop_out_valid[s]), 64'(0));
      check("rst_pop_key", 64'(pop_key[s]), 64'(0));
      check("rst_pop_val", 64'(pop_val[s]), 64'(0));
    end

    // Basic ordering in both modes, then tie stability.
    add(0, 1, 0, 5, 16'h000A, 0, 0, 1);
    add(0, 1, 0, 3, 16'h000B, 0, 0, 2);
    add(0, 1, 0, 8, 16'h000C, 0, 0, 3);
    add(0, 1, 0, 1, 16'h000D, 0, 0, 4);
    add(0, 0, 1, 0, 0, 1, 16'h000D, 3);
    add(0, 0, 1, 0, 0, 3, 16'h000B, 2);
    add(0, 0, 1, 0, 0, 5, 16'h000A, 1);
    add(0, 0, 1, 0, 0, 8, 16'h000C, 0);
    add(1, 1, 0, 5, 16'h000A, 0, 0, 1);
    add(1, 1, 0, 3, 16'h000B, 0, 0, 2);
    add(1, 1, 0, 8, 16'h000C, 0, 0, 3);
    add(1, 1, 0, 1, 16'h000D, 0, 0, 4);
    add(1, 0, 1, 0, 0, 8, 16'h000C, 3);
    add(1, 0, 1, 0, 0, 5, 16'h000A, 2);
    add(1, 0, 1, 0, 0, 3, 16'h000B, 1);
    add(1, 0, 1, 0, 0, 1, 16'h000D, 0);
    add(0, 1, 0, 2, 16'h00E1, 0, 0, 1);
    add(0, 1, 0, 2, 16'h00E2, 0, 0, 2);
    add(0, 0, 1, 0, 0, 2, 16'h00E1, 1);
    add(0, 0, 1, 0, 0, 2, 16'h00E2, 0);
    foreach (vt[i]) begin
      op(vt[i].s, vt[i].pu, vt[i].po, vt[i].key, vt[i].val, 1'b1, vt[i].ek, vt[i].ev);
      wait_idle(vt[i].s);
      check($sformatf("vec%0d_count", i), 64'(count[vt[i].s]), 64'(vt[i].ecnt));
    end
    check("vec_empty0", 64'(empty[0]), 64'(1));
    check("vec_empty1", 64'(empty[1]), 64'(1));

    // Fill to capacity, blocked push, replace-top on a full heap, then drain.
    keys3 = '{40, 10, 70, 20, 60, 30, 50};
    foreach (keys3[i]) op(0, 1, 0, keys3[i], vof(keys3[i]), 1'b0, 0, 0);
    wait_idle(0);
    check("full_count", 64'(count[0]), 64'(7));
    check("full_flag",  64'(full[0]),  64'(1));
    check("full_push_ready", 64'(push_ready[0]), 64'(0));
    push_valid[0] = 1'b1; push_key[0] = 5; push_val[0] = vof(5);
    #1;
    check("held_push_ready", 64'(push_ready[0]), 64'(0));
    for (int i = 0; i < 3; i++) tick();
    push_valid[0] = 1'b0;
    check("held_count", 64'(count[0]), 64'(7));
    op(0, 1, 1, 0, vof(0), 1'b1, 10, vof(10));
    wait_idle(0);
    check("replace_count", 64'(count[0]), 64'(7));
    op(0, 0, 1, 0, 0, 1'b1, 0, vof(0));
    for (int k = 20; k <= 70; k += 10) op(0, 0, 1, 0, 0, 1'b1, 32'(k), vof(32'(k)));
    wait_idle(0);
    check("drain_empty", 64'(empty[0]), 64'(1));

    // Flush landing while a pop is sifting down.
    foreach (keys3[i]) if (i < 5) op(0, 1, 0, keys3[i], vof(keys3[i]), 1'b0, 0, 0);
    wait_idle(0);
    pop_valid[0] = 1'b1;
    #1;
    sb_push(0, 10, vof(10));
    tick();
    pop_valid[0] = 1'b0;
    drain_check(0);
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0;
    #1;
    check("flush_count", 64'(count[0]), 64'(0));
    check("flush_empty", 64'(empty[0]), 64'(1));
    check("flush_idle",  64'(push_ready[0]), 64'(1));
    op(0, 1, 0, 9, vof(9), 1'b0, 0, 0);
    op(0, 0, 1, 0, 0, 1'b1, 9, vof(9));

    // Random traffic against the list model, each mode in turn.
    for (int s = 0; s < 2; s++) begin
      mdl_s = s;
      mdl.delete();
      flush[s] = 1'b1;
      tick();
      flush[s] = 1'b0;
      chk_cnt = 1'b1;
      for (int i = 0; i < 1500; i++) rand_op(s);
      wait_idle(s);
      chk_cnt = 1'b0;
    end
    drain_check(0);
    drain_check(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
